// File: rtl/mole_pkg.sv
// Shared hole codes, FSM states and index helpers for the mole generator and scorer.
package mole_pkg;

    localparam logic [2:0] MOLE_NONE = 3'b000;
    localparam logic [2:0] MOLE_A    = 3'b010;
    localparam logic [2:0] MOLE_W    = 3'b001;
    localparam logic [2:0] MOLE_D    = 3'b100;
    localparam logic [2:0] MOLE_X    = 3'b101;
    localparam logic [2:0] MOLE_S    = 3'b011;
    localparam logic [2:0] IDX_NONE  = 3'd7;

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        SHOW = 2'd1,
        LOST = 2'd2
    } state_e;

    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return MOLE_A;
            3'd1:    return MOLE_W;
            3'd2:    return MOLE_D;
            3'd3:    return MOLE_X;
            3'd4:    return MOLE_S;
            default: return MOLE_NONE;
        endcase
    endfunction

    // Fold random bits into 0..4 and step past the previous hole to avoid repeats.
    function automatic logic [2:0] pick_idx(input logic [2:0] rnd, input logic [2:0] prev);
        logic [2:0] cand;
        cand = (rnd >= 3'd5) ? rnd - 3'd5 : rnd;
        if (cand == prev) begin
            cand = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
        end
        return cand;
    endfunction

endpackage

// File: rtl/mole_generator_if.sv
// Mole position bus between the generator (master) and the scorer (slave).
interface mole_generator_if;
    logic [2:0] mole_pos;
    logic       mole_valid;
    logic       hit;

    modport master (output mole_pos, output mole_valid, input hit);
    modport slave  (input mole_pos, input mole_valid, output hit);
endinterface

// File: rtl/mole_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
module mole_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_generator.sv
// Picks a hole, shows the mole for a window, hides it on hit or timeout, counts misses.
module mole_generator
    import mole_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned MAX_MISSES  = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_esc,
    input  logic                     key_space,
    mole_generator_if.master         bus,
    output logic [2:0]               misses,
    output logic                     game_lose
);

    localparam int unsigned MAX_CYC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [2:0]         MISS_LIM  = 3'(MAX_MISSES);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         pos_q, pos_d;
    logic               valid_q, valid_d;
    logic [2:0]         misses_q, misses_d;
    logic               lose_q, lose_d;
    logic [2:0]         prev_q, prev_d;
    logic [7:0]         lfsr;
    logic [2:0]         next_idx;
    logic               lfsr_unused;

    mole_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .lfsr (lfsr)
    );

    assign lfsr_unused = ^lfsr[7:3];

    // Next-state and registered-output logic; esc beats pause, hit and timeout.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pos_d    = pos_q;
        valid_d  = valid_q;
        misses_d = misses_q;
        lose_d   = lose_q;
        prev_d   = prev_q;
        next_idx = pick_idx(lfsr[2:0], prev_q);

        if (key_esc) begin
            state_d  = GAP;
            timer_d  = '0;
            pos_d    = MOLE_NONE;
            valid_d  = 1'b0;
            misses_d = 3'd0;
            lose_d   = 1'b0;
            prev_d   = IDX_NONE;
        end else if (key_space && state_q != LOST) begin
            state_d = state_q;
        end else begin
            case (state_q)
                GAP: begin
                    pos_d   = MOLE_NONE;
                    valid_d = 1'b0;
                    if (timer_q == GAP_LAST) begin
                        pos_d   = idx_to_code(next_idx);
                        valid_d = 1'b1;
                        prev_d  = next_idx;
                        timer_d = '0;
                        state_d = SHOW;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                SHOW: begin
                    if (bus.hit) begin
                        pos_d   = MOLE_NONE;
                        valid_d = 1'b0;
                        timer_d = '0;
                        state_d = GAP;
                    end else if (timer_q == SHOW_LAST) begin
                        misses_d = misses_q + 3'd1;
                        pos_d    = MOLE_NONE;
                        valid_d  = 1'b0;
                        timer_d  = '0;
                        if (misses_d == MISS_LIM) begin
                            state_d = LOST;
                            lose_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                LOST: begin
                    pos_d   = MOLE_NONE;
                    valid_d = 1'b0;
                    lose_d  = 1'b1;
                    timer_d = '0;
                end
                default: begin
                    state_d = GAP;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GAP;
            timer_q  <= '0;
            pos_q    <= MOLE_NONE;
            valid_q  <= 1'b0;
            misses_q <= 3'd0;
            lose_q   <= 1'b0;
            prev_q   <= IDX_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            misses_q <= misses_d;
            lose_q   <= lose_d;
            prev_q   <= prev_d;
        end
    end

    assign bus.mole_pos   = pos_q;
    assign bus.mole_valid = valid_q;
    assign misses         = misses_q;
    assign game_lose      = lose_q;

endmodule
